axi4_sram_slave: RTL and testbench
==================================

Name: axi4_sram_slave

Overview:
AXI4 slave (responder) that backs an on-chip SRAM region. It serves INCR and FIXED read bursts to cache refill masters (ICache/DCache) and accepts byte-strobed write bursts. It is used for FPGA boot memory and as the memory model in cache test benches. The read and write channels run independent FSMs sharing one simple dual-port RAM (one write port, one read port).

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width (bytes per beat = DATA_WIDTH/8).
ID_WIDTH, 4, width of AR/AW/R/B id fields.
MEM_DEPTH, 4096, RAM depth in DATA_WIDTH words (power of 2).
BASE_ADDR, 32'h1C00_0000, byte address of word 0.
RD_WAIT, 1, extra idle cycles between AR handshake and first R beat (0..7).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
axi4_slv  AXI4.Slave  -  full AXI4 slave modport; uses aw_*, w_*, b_*, ar_*, r_*; ignores lock/cache/prot/qos/region/user (user outputs driven 0)

Behaviour:
- Reset (async, rst_n=0): read FSM→R_IDLE, write FSM→W_IDLE. ar_ready=1, aw_ready=1, r_valid=0, w_ready=0, b_valid=0. r_data, r_id, r_resp, r_last, b_id and b_resp = 0. RAM contents are not reset. Reset mid-burst abandons the burst; no response is issued.
- In-range check: BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8. Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
- Read FSM states: R_IDLE, R_WAIT, R_BURST.
  - R_IDLE: ar_ready=1. On ar_valid, latch id, addr, len, burst, size, and a beat counter = ar_len (AXI4 encoding: beats = ar_len+1). Go to R_WAIT if RD_WAIT>0, else R_BURST.
  - R_WAIT: count RD_WAIT cycles, then go to R_BURST.
  - R_BURST: RAM read latency is 1 cycle, so the RAM address is issued one cycle before r_valid rises. r_last=1 when counter==0.
  - While r_valid && !r_ready, all r_* outputs hold stable and the address does not advance.
  - On a beat handshake: INCR adds bytes-per-beat to addr; FIXED keeps addr.
  - After the last handshake, return to R_IDLE; ar_ready reasserts the next cycle. Minimum AR-to-first-R latency is RD_WAIT+1 cycles (2 at default).
- Read response:
  - r_resp=OKAY for in-range beats with ar_size==log2(DATA_WIDTH/8) and burst INCR or FIXED.
  - Out-of-range beat: DECERR (2'b11), r_data=0.
  - Bad size or WRAP/reserved burst: SLVERR (2'b10) on every beat, r_data=0.
  - The full len+1 beats are always returned.
  - r_id = latched ar_id.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: aw_ready=1. On aw_valid, latch id, addr, len, burst, size; go to W_DATA.
  - W_DATA: w_ready=1. Each handshake writes the bytes selected by w_strb to the RAM at the current word index (skipped when out-of-range or erroring), then advances addr as on the read side.
  - After len+1 beats, go to W_RESP.
  - If w_last does not match the expected final beat, record SLVERR; data beats are still consumed until the count is reached.
  - W_RESP: b_valid=1 with b_id and b_resp held until b_ready, then go to W_IDLE.
  - b_resp priority: DECERR (any beat out-of-range) > SLVERR > OKAY.
- Simultaneous read and write to the same word in the same cycle: the read returns old data (read-first). A write completed before the RAM read cycle is visible.
- AR and AW may be accepted in the same cycle. The channels are independent; no ordering is enforced between them.
- 4 KB boundary crossing is not checked; the address simply increments.

Decomposition:
- Shared axi package holds: AXI_BURST_FIXED/INCR/WRAP, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, and a typedef for the latched burst context (id, addr, len, burst, size).
- Sub-module: existing SimpleDualPortRAM, configured with DATA_WIDTH=DATA_WIDTH, BYTE_WRITE_WIDTH=8, common_clock, read_first.
- Read and write FSMs stay in this module.

Test Plan:
- Write 1 beat at BASE_ADDR, data 32'hDEADBEEF, strb 4'hF → b_resp=OKAY, b_id echoed. Then read len=0 → r_data=32'hDEADBEEF, r_last=1, first r_valid 2 cycles after the AR handshake.
- Preload words 0..3 = 1,2,3,4. Read INCR len=3 with r_ready toggling 1,0,0,1… → beats 1,2,3,4 in order; r_* held stable during stalls; r_last only on the 4th beat.
- Write strb 4'b0101 data 32'hAABBCCDD over 32'h11223344 → readback 32'h11BB33DD.
- Read at BASE_ADDR + MEM_DEPTH*4, len=1 → 2 beats, r_resp=2'b11, r_data=0. Write to the same address → b_resp=2'b11.
- Write len=3 with w_last asserted on beat 2 → 4 beats accepted, b_resp=2'b10.
- Deassert rst_n mid-read burst (after beat 1 of 4) → r_valid=0 immediately, ar_ready=1 after release; a new read returns correct data.

Source files
------------

// File: rtl/axi4_sram_slave_pkg.sv
// rtl/axi4_sram_slave_pkg.sv - AXI encodings, FSM states and latched burst context
package axi4_sram_slave_pkg;
   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_ADDR_WIDTH = 32;

   // len doubles as the remaining-beat down-counter once latched
   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [1:0]                burst;
      logic [2:0]                size;
   } axi_ctx_t;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
endpackage

// File: rtl/axi4_if.sv
// rtl/axi4_if.sv - AXI4 bus bundle with slave modport
interface axi4_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 1
);
   logic [ID_WIDTH-1:0]     aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic                    aw_lock;
   logic [3:0]              aw_cache;
   logic [2:0]              aw_prot;
   logic [3:0]              aw_qos;
   logic [3:0]              aw_region;
   logic [USER_WIDTH-1:0]   aw_user;
   logic                    aw_valid;
   logic                    aw_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;
   logic [USER_WIDTH-1:0]   w_user;
   logic                    w_valid;
   logic                    w_ready;
   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;
   logic [USER_WIDTH-1:0]   b_user;
   logic                    b_valid;
   logic                    b_ready;
   logic [ID_WIDTH-1:0]     ar_id;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;
   logic                    ar_lock;
   logic [3:0]              ar_cache;
   logic [2:0]              ar_prot;
   logic [3:0]              ar_qos;
   logic [3:0]              ar_region;
   logic [USER_WIDTH-1:0]   ar_user;
   logic                    ar_valid;
   logic                    ar_ready;
   logic [ID_WIDTH-1:0]     r_id;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;
   logic                    r_last;
   logic [USER_WIDTH-1:0]   r_user;
   logic                    r_valid;
   logic                    r_ready;

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/axi4_sram_slave_ram.sv
// rtl/axi4_sram_slave_ram.sv - simple dual-port RAM, byte-write, common clock, read-first
module axi4_sram_slave_ram #(
   parameter  int DATA_WIDTH       = 32,
   parameter  int BYTE_WRITE_WIDTH = 8,
   parameter  int DEPTH            = 4096,
   localparam int AW               = $clog2(DEPTH),
   localparam int NB               = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
   input  logic                  clk,
   input  logic [NB-1:0]         we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++)
         if (we[b]) mem[waddr][b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <= wdata[b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 slave serving INCR/FIXED bursts from on-chip SRAM
module axi4_sram_slave
   import axi4_sram_slave_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ID_WIDTH   = 4,
   parameter int                    MEM_DEPTH  = 4096,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1C00_0000,
   parameter int                    RD_WAIT    = 1
) (
   input logic  clk,
   input logic  rst_n,
   axi4_if.slave axi4_slv
);
   localparam int     BPB      = DATA_WIDTH / 8;
   localparam int     SIZE_LOG = $clog2(BPB);
   localparam int     IDX_W    = $clog2(MEM_DEPTH);
   localparam longint SPAN     = longint'(MEM_DEPTH) * BPB;

   function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = ADDR_WIDTH'(a) - BASE_ADDR;
      return (ADDR_WIDTH'(a) >= BASE_ADDR) && (64'(off) < 64'(SPAN));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
      return IDX_W'((ADDR_WIDTH'(a) - BASE_ADDR) >> SIZE_LOG);
   endfunction

   function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input axi_ctx_t c);
      return (c.burst == AXI_BURST_FIXED) ? c.addr : c.addr + AXI_ADDR_WIDTH'(BPB);
   endfunction

   // Bad size/burst wins on reads so every beat of such a burst reports SLVERR
   function automatic logic [1:0] beat_resp(input axi_ctx_t c, input logic [AXI_ADDR_WIDTH-1:0] a);
      if (c.size != 3'(SIZE_LOG) || !(c.burst == AXI_BURST_INCR || c.burst == AXI_BURST_FIXED))
         return AXI_RESP_SLVERR;
      if (!in_range(a)) return AXI_RESP_DECERR;
      return AXI_RESP_OKAY;
   endfunction

   rd_state_e rd_state, rd_next;
   wr_state_e wr_state, wr_next;
   axi_ctx_t  rd_ctx, wr_ctx;
   logic [2:0] rd_wait;
   logic       rd_valid_q, rd_hs, rd_en;
   logic [1:0] rd_resp_q;
   logic [AXI_ADDR_WIDTH-1:0] rd_fetch;
   logic [DATA_WIDTH-1:0]     rd_q;
   logic       wr_hs, wr_dec, wr_slv, wr_last_bad;
   logic [1:0] wr_beat, b_resp_q;
   logic [ID_WIDTH-1:0] b_id_q;
   logic [BPB-1:0]      ram_we;

   // ---------------- read channel ----------------
   assign rd_hs = rd_valid_q && axi4_slv.r_ready;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rd_state <= R_IDLE;
      else        rd_state <= rd_next;

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (axi4_slv.ar_valid) rd_next = (RD_WAIT > 0) ? R_WAIT : R_BURST;
         R_WAIT:  if (rd_wait == 3'd0) rd_next = R_BURST;
         R_BURST: if (rd_hs && rd_ctx.len == 8'd0) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   // RAM read is issued one cycle ahead of r_valid: on burst entry and on each non-final handshake
   always_comb begin
      axi4_slv.ar_ready = (rd_state == R_IDLE);
      rd_en    = 1'b0;
      rd_fetch = rd_ctx.addr;
      if (rd_state == R_BURST) begin
         if (!rd_valid_q) rd_en = 1'b1;
         else if (rd_hs && rd_ctx.len != 8'd0) begin
            rd_en    = 1'b1;
            rd_fetch = next_addr(rd_ctx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ctx     <= '0;
         rd_wait    <= '0;
         rd_valid_q <= 1'b0;
         rd_resp_q  <= AXI_RESP_OKAY;
      end else begin
         if (rd_state == R_IDLE && axi4_slv.ar_valid) begin
            rd_ctx  <= '{id: AXI_ID_WIDTH'(axi4_slv.ar_id), addr: AXI_ADDR_WIDTH'(axi4_slv.ar_addr),
                         len: axi4_slv.ar_len, burst: axi4_slv.ar_burst, size: axi4_slv.ar_size};
            rd_wait <= 3'(RD_WAIT - 1);
         end
         if (rd_state == R_WAIT) rd_wait <= rd_wait - 3'd1;
         if (rd_en) begin
            rd_ctx.addr <= rd_fetch;
            if (rd_valid_q) rd_ctx.len <= rd_ctx.len - 8'd1;
            rd_valid_q  <= 1'b1;
            rd_resp_q   <= beat_resp(rd_ctx, rd_fetch);
         end else if (rd_hs) begin
            rd_valid_q  <= 1'b0;
         end
      end

   assign axi4_slv.r_valid = rd_valid_q;
   assign axi4_slv.r_resp  = rd_resp_q;
   assign axi4_slv.r_last  = rd_valid_q && (rd_ctx.len == 8'd0);
   assign axi4_slv.r_id    = rd_valid_q ? ID_WIDTH'(rd_ctx.id) : '0;
   assign axi4_slv.r_data  = (rd_valid_q && rd_resp_q == AXI_RESP_OKAY) ? rd_q : '0;
   assign axi4_slv.r_user  = '0;

   // ---------------- write channel ----------------
   assign wr_hs       = (wr_state == W_DATA) && axi4_slv.w_valid;
   assign wr_beat     = beat_resp(wr_ctx, wr_ctx.addr);
   assign wr_last_bad = axi4_slv.w_last != (wr_ctx.len == 8'd0);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) wr_state <= W_IDLE;
      else        wr_state <= wr_next;

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE:  if (axi4_slv.aw_valid) wr_next = W_DATA;
         W_DATA:  if (wr_hs && wr_ctx.len == 8'd0) wr_next = W_RESP;
         W_RESP:  if (axi4_slv.b_ready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      axi4_slv.aw_ready = (wr_state == W_IDLE);
      axi4_slv.w_ready  = (wr_state == W_DATA);
      axi4_slv.b_valid  = (wr_state == W_RESP);
      ram_we            = (wr_hs && wr_beat == AXI_RESP_OKAY) ? axi4_slv.w_strb : '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ctx   <= '0;
         wr_dec   <= 1'b0;
         wr_slv   <= 1'b0;
         b_id_q   <= '0;
         b_resp_q <= AXI_RESP_OKAY;
      end else begin
         if (wr_state == W_IDLE && axi4_slv.aw_valid) begin
            wr_ctx <= '{id: AXI_ID_WIDTH'(axi4_slv.aw_id), addr: AXI_ADDR_WIDTH'(axi4_slv.aw_addr),
                        len: axi4_slv.aw_len, burst: axi4_slv.aw_burst, size: axi4_slv.aw_size};
            wr_dec <= 1'b0;
            wr_slv <= 1'b0;
         end
         if (wr_hs) begin
            wr_ctx.addr <= next_addr(wr_ctx);
            wr_ctx.len  <= wr_ctx.len - 8'd1;
            wr_dec      <= wr_dec | (wr_beat == AXI_RESP_DECERR);
            wr_slv      <= wr_slv | (wr_beat == AXI_RESP_SLVERR) | wr_last_bad;
            if (wr_ctx.len == 8'd0) begin
               b_id_q   <= ID_WIDTH'(wr_ctx.id);
               b_resp_q <= (wr_dec || wr_beat == AXI_RESP_DECERR) ? AXI_RESP_DECERR :
                           (wr_slv || wr_beat == AXI_RESP_SLVERR || wr_last_bad) ? AXI_RESP_SLVERR :
                           AXI_RESP_OKAY;
            end
         end
      end

   assign axi4_slv.b_id   = b_id_q;
   assign axi4_slv.b_resp = b_resp_q;
   assign axi4_slv.b_user = '0;

   axi4_sram_slave_ram #(
      .DATA_WIDTH      (DATA_WIDTH),
      .BYTE_WRITE_WIDTH(8),
      .DEPTH           (MEM_DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(word_idx(wr_ctx.addr)),
      .wdata(axi4_slv.w_data),
      .re   (rd_en),
      .raddr(word_idx(rd_fetch)),
      .rdata(rd_q)
   );
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - directed self-checking bench for axi4_sram_slave
module tb_axi4_sram_slave;
   localparam logic [31:0] BASE  = 32'h1C00_0000;
   localparam logic [1:0]  FIXED = 2'b00;
   localparam logic [1:0]  INCR  = 2'b01;
   localparam logic [1:0]  WRAP  = 2'b10;

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   stall_bad;

   logic [31:0] wr_data [16];
   logic [3:0]  wr_strb [16];
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_id   [16];

   axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

   axi4_sram_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4),
      .MEM_DEPTH(4096), .BASE_ADDR(BASE), .RD_WAIT(1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .axi4_slv(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int last_at,
                            output logic [1:0] bresp, output logic [3:0] bid, output int beats);
      int t;
      bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
      bus.aw_size = 3'd2; bus.aw_burst = burst; bus.aw_valid = 1'b1;
      t = 0;
      while (!bus.aw_ready && t < 100) begin @(negedge clk); t++; end
      check("aw_ready", bus.aw_ready, 1);
      @(negedge clk);
      bus.aw_valid = 1'b0;
      beats = 0;
      for (int i = 0; i <= int'(len); i++) begin
         bus.w_data = wr_data[i]; bus.w_strb = wr_strb[i];
         bus.w_last = (i == last_at); bus.w_valid = 1'b1;
         t = 0;
         while (!bus.w_ready && t < 100) begin @(negedge clk); t++; end
         if (bus.w_ready) beats++;
         @(negedge clk);
      end
      bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.b_ready = 1'b1;
      t = 0;
      while (!bus.b_valid && t < 100) begin @(negedge clk); t++; end
      check("b_valid", bus.b_valid, 1);
      bresp = bus.b_resp;
      bid   = bus.b_id;
      @(negedge clk);
      bus.b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input bit stall,
                           output int lat);
      int t, n, v;
      bit stalled, rdy;
      logic [38:0] held;
      bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
      bus.ar_size = size; bus.ar_burst = burst; bus.ar_valid = 1'b1;
      t = 0;
      while (!bus.ar_ready && t < 100) begin @(negedge clk); t++; end
      check("ar_ready", bus.ar_ready, 1);
      @(negedge clk);
      bus.ar_valid = 1'b0;
      lat = 0;
      while (!bus.r_valid && lat < 100) begin @(negedge clk); lat++; end
      n = 0; v = 0; t = 0; stalled = 1'b0; held = '0;
      while (n <= int'(len) && t < 200) begin
         if (bus.r_valid) begin
            if (stalled && {bus.r_data, bus.r_resp, bus.r_last, bus.r_id} != held) stall_bad++;
            rdy = !stall || (v % 4 == 0) || (v % 4 == 3);
            bus.r_ready = rdy;
            v++;
            if (rdy) begin
               rd_data[n] = bus.r_data; rd_resp[n] = bus.r_resp;
               rd_last[n] = bus.r_last; rd_id[n]   = bus.r_id;
               n++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = {bus.r_data, bus.r_resp, bus.r_last, bus.r_id};
            end
         end else begin
            bus.r_ready = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      bus.r_ready = 1'b0;
      check("rd_beats", n, int'(len) + 1);
   endtask

   initial begin
      logic [1:0] br;
      logic [3:0] bi;
      int nb, lat, t;

      rst_n = 1'b0;
      bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
      bus.aw_lock = '0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_qos = '0; bus.aw_region = '0;
      bus.aw_user = '0; bus.aw_valid = 1'b0;
      bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_user = '0; bus.w_valid = 1'b0;
      bus.b_ready = 1'b0;
      bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
      bus.ar_lock = '0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_qos = '0; bus.ar_region = '0;
      bus.ar_user = '0; bus.ar_valid = 1'b0;
      bus.r_ready = 1'b0;
      stall_bad = 0;
      repeat (3) @(negedge clk);

      check("rst_ar_ready", bus.ar_ready, 1);
      check("rst_aw_ready", bus.aw_ready, 1);
      check("rst_r_valid",  bus.r_valid, 0);
      check("rst_w_ready",  bus.w_ready, 0);
      check("rst_b_valid",  bus.b_valid, 0);
      check("rst_r_data",   bus.r_data, 0);
      check("rst_r_id",     bus.r_id, 0);
      check("rst_r_resp",   bus.r_resp, 0);
      check("rst_r_last",   bus.r_last, 0);
      check("rst_b_id",     bus.b_id, 0);
      check("rst_b_resp",   bus.b_resp, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single beat write then read back
      wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
      axi_write(4'd5, BASE, 8'd0, INCR, 0, br, bi, nb);
      check("single_bresp", br, 2'b00);
      check("single_bid", bi, 4'd5);
      axi_read(4'd3, BASE, 8'd0, INCR, 3'd2, 1'b0, lat);
      check("single_lat", lat, 2);
      check("single_rdata", rd_data[0], 32'hDEADBEEF);
      check("single_rlast", rd_last[0], 1);
      check("single_rresp", rd_resp[0], 2'b00);
      check("single_rid", rd_id[0], 4'd3);

      // INCR burst with r_ready back-pressure
      for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
      axi_write(4'd1, BASE, 8'd3, INCR, 3, br, bi, nb);
      check("preload_bresp", br, 2'b00);
      stall_bad = 0;
      axi_read(4'd2, BASE, 8'd3, INCR, 3'd2, 1'b1, lat);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("incr_data%0d", i), rd_data[i], 32'(i + 1));
         check($sformatf("incr_last%0d", i), rd_last[i], (i == 3) ? 1 : 0);
      end
      check("incr_stall_stable", stall_bad, 0);

      // byte strobes
      wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
      axi_write(4'd0, BASE + 32'h20, 8'd0, INCR, 0, br, bi, nb);
      wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
      axi_write(4'd0, BASE + 32'h20, 8'd0, INCR, 0, br, bi, nb);
      axi_read(4'd0, BASE + 32'h20, 8'd0, INCR, 3'd2, 1'b0, lat);
      check("strb_data", rd_data[0], 32'h11BB33DD);

      // out-of-range just past the end of the window
      axi_read(4'd9, BASE + 32'h4000, 8'd1, INCR, 3'd2, 1'b0, lat);
      check("oor_resp0", rd_resp[0], 2'b11);
      check("oor_resp1", rd_resp[1], 2'b11);
      check("oor_data0", rd_data[0], 0);
      check("oor_last0", rd_last[0], 0);
      check("oor_last1", rd_last[1], 1);
      check("oor_rid", rd_id[1], 4'd9);
      wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
      axi_write(4'd4, BASE + 32'h4000, 8'd0, INCR, 0, br, bi, nb);
      check("oor_bresp", br, 2'b11);

      // w_last on the wrong beat
      for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
      axi_write(4'd7, BASE + 32'h40, 8'd3, INCR, 1, br, bi, nb);
      check("wlast_beats", nb, 4);
      check("wlast_bresp", br, 2'b10);
      check("wlast_bid", bi, 4'd7);

      // FIXED burst repeats one word; bad size and WRAP give SLVERR
      axi_read(4'd1, BASE + 32'h4, 8'd2, FIXED, 3'd2, 1'b0, lat);
      for (int i = 0; i < 3; i++) check($sformatf("fixed_data%0d", i), rd_data[i], 32'd2);
      axi_read(4'd1, BASE, 8'd0, INCR, 3'd1, 1'b0, lat);
      check("badsize_resp", rd_resp[0], 2'b10);
      check("badsize_data", rd_data[0], 0);
      axi_read(4'd1, BASE, 8'd1, WRAP, 3'd2, 1'b0, lat);
      check("wrap_resp1", rd_resp[1], 2'b10);

      // reset in the middle of a read burst
      bus.ar_id = 4'd6; bus.ar_addr = BASE; bus.ar_len = 8'd3;
      bus.ar_size = 3'd2; bus.ar_burst = INCR; bus.ar_valid = 1'b1;
      t = 0;
      while (!bus.ar_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      bus.ar_valid = 1'b0;
      t = 0;
      while (!bus.r_valid && t < 100) begin @(negedge clk); t++; end
      check("mid_beat1", bus.r_data, 32'd1);
      bus.r_ready = 1'b1;
      @(negedge clk);
      bus.r_ready = 1'b0;
      check("mid_valid_pre", bus.r_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rvalid_rst", bus.r_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_ar_ready", bus.ar_ready, 1);
      axi_read(4'd2, BASE + 32'h4, 8'd0, INCR, 3'd2, 1'b0, lat);
      check("mid_reread", rd_data[0], 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
